// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatcher.
package demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin channel picker: first enabled channel strictly after ptr,
// wrapping 3->0. When ptr is the only enabled channel it is picked again.
module rr_next_ch
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_CH-1:0]  enable,
  output logic [SEL_W-1:0] next,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    next = ptr;
    any  = |enable;
    for (int i = N_CH; i >= 1; i--) begin
      if (enable[ptr + SEL_W'(i)]) begin
        next = ptr + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/demux_dispatcher.sv
// Serial-bit dispatcher feeding a 1-to-4 demux. Fixed-length bursts are
// steered to enabled channels in round-robin order, with a break-before-make
// gap (dout low) between bursts so sel never moves while a bit is on dout.
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = $clog2(BURST_LEN + GAP_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  input  logic [N_CH-1:0]  ch_enable,
  output logic [SEL_W-1:0] sel,
  output logic             dout,
  output logic             dout_valid,
  output logic             burst_done
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dout_d, dout_valid_d, burst_done_d;
  logic [SEL_W-1:0]   rr_next;
  logic               rr_any;
  logic               xfer;

  // in_ready depends on state only, so upstream sees no path from in_valid.
  assign in_ready = (state_q == SEND);
  assign xfer     = in_valid & in_ready;

  rr_next_ch u_rr (
    .ptr    (ptr_q),
    .enable (ch_enable),
    .next   (rr_next),
    .any    (rr_any)
  );

  // Next-state and next-output decode. cnt counts accepted bits in SEND and
  // elapsed cycles in GAP; it is cleared on every state change into SEND/GAP.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    burst_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          sel_d   = rr_next;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          dout_d       = in_data;
          dout_valid_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
        // A bit accepted in the same cycle the channel is disabled is still
        // delivered; the burst ends right after it.
        if ((xfer && (cnt_q == BURST_LAST)) || !ch_enable[sel]) begin
          state_d      = GAP;
          burst_done_d = 1'b1;
          ptr_d        = sel;
          cnt_d        = '0;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rr_any) begin
            sel_d   = rr_next;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; the pointer resets to the last channel so
  // the first grant lands on channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel        <= '0;
      ptr_q      <= SEL_W'(N_CH - 1);
      cnt_q      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      sel        <= sel_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      burst_done <= burst_done_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: a driver advances a behavioural
// model each cycle and queues every bit it expects on dout; a monitor pops
// and compares whenever the DUT presents a cycle.
module tb_demux_dispatcher;

  localparam int BURST_LEN  = 8;
  localparam int GAP_CYCLES = 1;
  localparam int PH_IDLE = 0;
  localparam int PH_SEND = 1;
  localparam int PH_GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic [3:0] ch_enable = 4'b0000;
  logic       in_ready;
  logic [1:0] sel;
  logic       dout;
  logic       dout_valid;
  logic       burst_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int sel;
    int bit_v;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_x;

  // Behavioural model state: phase, granted channel, last-served channel,
  // bits delivered in this burst, gap cycles still to run, burst_done now.
  int m_phase, m_sel, m_ptr, m_bits, m_gap, m_done;

  demux_dispatcher #(
    .BURST_LEN  (BURST_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ch_enable  (ch_enable),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Next enabled channel after ptr, searching ptr+1 .. ptr+4 modulo 4.
  function automatic int grant(input int ptr, input logic [3:0] en);
    for (int k = 1; k <= 4; k++) begin
      if (en[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_sel   = 0;
    m_ptr   = 3;
    m_bits  = 0;
    m_gap   = 0;
    m_done  = 0;
    exp_q.delete();
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_advance(input logic v, input logic d, input logic [3:0] en);
    int g;
    int nd;
    nd = 0;
    if (m_phase == PH_IDLE) begin
      g = grant(m_ptr, en);
      if (g >= 0) begin
        m_sel   = g;
        m_bits  = 0;
        m_phase = PH_SEND;
      end
    end else if (m_phase == PH_SEND) begin
      if (v) begin
        exp_q.push_back('{cyc + 1, m_sel, int'(d)});
        m_bits++;
      end
      if ((v && m_bits == BURST_LEN) || !en[m_sel]) begin
        m_phase = PH_GAP;
        nd      = 1;
        m_ptr   = m_sel;
        m_bits  = 0;
        m_gap   = GAP_CYCLES;
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        g = grant(m_ptr, en);
        if (g >= 0) begin
          m_sel   = g;
          m_phase = PH_SEND;
        end else begin
          m_phase = PH_IDLE;
        end
      end
    end
    m_done = nd;
  endtask

  // One clock cycle: check state-derived outputs, apply inputs, advance model.
  task automatic step(input logic v, input logic d, input logic [3:0] en);
    check("in_ready", int'(in_ready), int'(m_phase == PH_SEND));
    check("sel", int'(sel), m_sel);
    check("burst_done", int'(burst_done), m_done);
    in_valid  = v;
    in_data   = d;
    ch_enable = en;
    model_advance(v, d, en);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sel", int'(sel), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_burst_done", int'(burst_done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle out of reset, compare dout/dout_valid/sel against
  // the queued bit expected for this cycle (if any).
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_x = exp_q.pop_front();
        check("dout_valid", int'(dout_valid), 1);
        check("dout", int'(dout), mon_x.bit_v);
        check("dout_sel", int'(sel), mon_x.sel);
      end else begin
        check("dout_valid", int'(dout_valid), 0);
        check("dout_bubble_low", int'(dout), 0);
      end
    end
  end

  initial begin
    logic [7:0] pat;
    logic [3:0] en;
    pat = 8'b1011_0010;
    model_reset();

    // Full rotation over all channels with continuous valid.
    do_reset();
    for (int i = 0; i < 45; i++) step(1'b1, pat[7 - (i % 8)], 4'b1111);

    // Two enabled channels alternate; 1 and 3 are skipped.
    for (int i = 0; i < 45; i++) step(1'b1, 1'(i % 3 == 0), 4'b0101);

    // Channel 0 disabled after three of its bits were accepted.
    do_reset();
    step(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 4'b1111);
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2), 4'b1110);

    // Nothing enabled: stays idle, then channel 3 alone.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 25; i++) step(1'b1, 1'(i % 2), 4'b1000);

    // in_valid toggles every other cycle.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'(i % 2), 1'(i % 3 == 1), 4'b1111);

    // Reset in the middle of a burst, then a fresh full burst on channel 0.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b1111);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, pat[i % 8], 4'b1111);

    // Random traffic with occasional enable changes and rare resets.
    en = 4'b1111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) en = 4'($urandom_range(15));
      if ($urandom_range(299) == 0) do_reset();
      step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), en);
    end

    // Drain: let the last accepted bit reach the monitor.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
